// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
// Program counter, instruction register and data-address register that sit
// directly below the control FSM. The unit drives the RAM address, holds the
// fetched instruction, decodes its fields for the FSM, and evaluates branch
// conditions against the datapath status flags.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous reset, active-low
//   reset_pc     synchronous PC clear strobe (wins over load_pc)
//   load_pc      PC update enable
//   pc_sel       next PC: 00 pc+1, 01 conditional branch, 10 datapath_out, 11 hold
//   addr_sel     1: mem_addr = pc, 0: mem_addr = data-address register
//   load_ir      instruction register load enable
//   load_addr    data-address register load enable
//   mdata        RAM read data
//   datapath_out datapath result; the low PC_W bits are used
//   N, V, Z      datapath status flags
//   mem_addr     RAM address
//   pc, ir       current PC and instruction
//   opcode/op/cond, sximm5/sximm8  decoded instruction fields
//   cond_true    branch condition currently satisfied
//   instr_count  saturating count of instruction loads since reset
module fetch_pc_unit #(
    parameter int PC_W  = 9,
    parameter int IR_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_pc,
    input  logic              load_pc,
    input  logic [1:0]        pc_sel,
    input  logic              addr_sel,
    input  logic              load_ir,
    input  logic              load_addr,
    input  logic [IR_W-1:0]   mdata,
    input  logic [15:0]       datapath_out,
    input  logic              N,
    input  logic              V,
    input  logic              Z,
    output logic [PC_W-1:0]   mem_addr,
    output logic [PC_W-1:0]   pc,
    output logic [IR_W-1:0]   ir,
    output logic [2:0]        opcode,
    output logic [1:0]        op,
    output logic [2:0]        cond,
    output logic [15:0]       sximm5,
    output logic [15:0]       sximm8,
    output logic              cond_true,
    output logic [CNT_W-1:0]  instr_count
);

    logic [PC_W-1:0]    data_addr;
    logic [PC_W-1:0]    pc_next;
    logic signed [15:0] imm5_s;
    logic signed [15:0] imm8_s;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}})
            return v;
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Decode: fields come straight from the held instruction.
    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign cond   = ir[10:8];
    assign imm5_s = {{11{ir[4]}}, ir[4:0]};
    assign imm8_s = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = imm5_s;
    assign sximm8 = imm8_s;

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = Z;
            3'b010:  cond_true = ~Z;
            3'b011:  cond_true = N ^ V;
            3'b100:  cond_true = (N ^ V) | Z;
            default: cond_true = 1'b0;
        endcase
    end

    // Next-PC select. The PC already points past the branch, so a taken
    // branch adds the offset with no extra +1; additions wrap at PC_W bits.
    always_comb begin
        pc_next = pc;
        case (pc_sel)
            2'b00:   pc_next = pc + PC_W'(1);
            2'b01:   pc_next = cond_true ? (pc + imm8_s[PC_W-1:0]) : pc;
            2'b10:   pc_next = datapath_out[PC_W-1:0];
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else if (reset_pc) begin
            pc <= '0;
        end else if (load_pc) begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir          <= '0;
            instr_count <= '0;
        end else if (load_ir) begin
            ir          <= mdata;
            instr_count <= sat_inc(instr_count);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_addr <= '0;
        end else if (load_addr) begin
            data_addr <= datapath_out[PC_W-1:0];
        end
    end

    assign mem_addr = addr_sel ? pc : data_addr;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        reset_pc, load_pc, addr_sel, load_ir, load_addr;
    logic [1:0]  pc_sel;
    logic [15:0] mdata, datapath_out;
    logic        N, V, Z;
    logic [8:0]  mem_addr, pc;
    logic [15:0] ir;
    logic [2:0]  opcode, cond;
    logic [1:0]  op;
    logic [15:0] sximm5, sximm8;
    logic        cond_true;
    logic [15:0] instr_count;

    int n_chk = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    fetch_pc_unit #(.PC_W(9), .IR_W(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .reset_pc(reset_pc), .load_pc(load_pc),
        .pc_sel(pc_sel), .addr_sel(addr_sel), .load_ir(load_ir),
        .load_addr(load_addr), .mdata(mdata), .datapath_out(datapath_out),
        .N(N), .V(V), .Z(Z), .mem_addr(mem_addr), .pc(pc), .ir(ir),
        .opcode(opcode), .op(op), .cond(cond), .sximm5(sximm5),
        .sximm8(sximm8), .cond_true(cond_true), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset_pc = 0; load_pc = 0; pc_sel = 2'b11; load_ir = 0; load_addr = 0;
    endtask

    task automatic set_pc(input logic [15:0] v);
        load_pc = 1; pc_sel = 2'b10; datapath_out = v;
        tick();
        load_pc = 0;
    endtask

    task automatic load_instr(input logic [15:0] w);
        load_ir = 1; mdata = w;
        tick();
        load_ir = 0;
        if (exp_cnt < 65535) exp_cnt++;
    endtask

    initial begin
        reset = 0;
        // Random activity while reset is held low.
        for (int i = 0; i < 4; i++) begin
            {reset_pc, load_pc, addr_sel, load_ir, load_addr} = 5'($urandom);
            pc_sel = 2'($urandom); mdata = 16'($urandom);
            datapath_out = 16'($urandom); {N, V, Z} = 3'($urandom);
            tick();
        end
        idle(); addr_sel = 1; N = 0; V = 0; Z = 0; mdata = 0; datapath_out = 0;
        #2 reset = 1;
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_ir", ir, 0);
        chk("rst_cnt", instr_count, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_cond_true", cond_true, 1);
        chk("rst_sximm8", sximm8, 0);
        addr_sel = 0; #1;
        chk("rst_maddr_data", mem_addr, 0);
        addr_sel = 1;

        // reset_pc from 0x005
        set_pc(16'h0005);
        chk("pc_preset5", pc, 9'h005);
        reset_pc = 1; load_pc = 1; pc_sel = 2'b00;
        tick(); idle();
        chk("reset_pc", pc, 0);

        // Fetch
        load_instr(16'hD105);
        chk("fetch_ir", ir, 16'hD105);
        chk("fetch_opcode", opcode, 3'b110);
        chk("fetch_op", op, 2'b10);
        chk("fetch_cond", cond, 3'b001);
        chk("fetch_sximm5", sximm5, 16'h0005);
        chk("fetch_cnt", instr_count, 1);
        load_pc = 1; pc_sel = 2'b00;
        tick(); idle();
        chk("fetch_pc_inc", pc, 9'h001);
        chk("fetch_maddr", mem_addr, 9'h001);
        set_pc(16'h01FF);
        load_pc = 1; pc_sel = 2'b00;
        tick(); idle();
        chk("pc_wrap", pc, 9'h000);

        // Conditional branch, cond=001, offset -2
        load_instr(16'h21FE);
        chk("br_sximm8", sximm8, 16'hFFFE);
        chk("br_sximm5", sximm5, 16'hFFFE);
        set_pc(16'h0010);
        Z = 1; #1;
        chk("br_ct_z1", cond_true, 1);
        load_pc = 1; pc_sel = 2'b01;
        tick(); idle();
        chk("br_taken", pc, 9'h00E);
        set_pc(16'h0010);
        Z = 0; #1;
        chk("br_ct_z0", cond_true, 0);
        load_pc = 1; pc_sel = 2'b01;
        tick(); idle();
        chk("br_not_taken", pc, 9'h010);

        // cond=100 with N=1,V=0,Z=0 -> taken, offset +3
        load_instr(16'h0403);
        N = 1; V = 0; Z = 0; #1;
        chk("c100_ct", cond_true, 1);
        load_pc = 1; pc_sel = 2'b01;
        tick(); idle();
        chk("c100_pc", pc, 9'h013);
        // cond=011 with N=1,V=1 -> false
        load_instr(16'h0303);
        V = 1; #1;
        chk("c011_ct", cond_true, 0);
        V = 0; #1;
        chk("c011_ct_nv", cond_true, 1);
        // cond=101 never taken
        load_instr(16'h0503);
        Z = 1; #1;
        chk("c101_ct", cond_true, 0);
        load_pc = 1; pc_sel = 2'b01;
        tick(); idle();
        chk("c101_pc", pc, 9'h013);
        N = 0; Z = 0;

        // Register branch and data address
        set_pc(16'hFE23);
        chk("reg_branch", pc, 9'h023);
        load_addr = 1; datapath_out = 16'h0140;
        tick(); idle();
        addr_sel = 0; #1;
        chk("maddr_data", mem_addr, 9'h140);
        addr_sel = 1; #1;
        chk("maddr_pc", mem_addr, 9'h023);

        // Priority and hold
        reset_pc = 1; load_pc = 1; pc_sel = 2'b10; datapath_out = 16'h00AA;
        tick(); idle();
        chk("prio_reset_pc", pc, 0);
        set_pc(16'h00AA);
        load_pc = 1; pc_sel = 2'b11;
        tick(); idle();
        chk("sel11_hold", pc, 9'h0AA);
        pc_sel = 2'b00;
        tick();
        chk("no_load_hold", pc, 9'h0AA);
        chk("cnt_survives_reset_pc", instr_count, 16'(exp_cnt));

        // Saturation
        load_ir = 1; mdata = 16'h1111;
        while (exp_cnt < 65535) begin
            tick();
            exp_cnt++;
        end
        chk("cnt_full", instr_count, 16'hFFFF);
        tick();
        chk("cnt_saturate", instr_count, 16'hFFFF);

        // Async reset between edges while load_ir is high
        mdata = 16'h1234;
        tick();
        chk("ir_pre_async", ir, 16'h1234);
        #2 reset = 0;
        #1;
        chk("async_ir", ir, 0);
        chk("async_cnt", instr_count, 0);
        chk("async_pc", pc, 0);
        idle();
        @(negedge clk);
        reset = 1;
        #1;
        chk("post_async_cnt", instr_count, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Program-counter, instruction-register and memory-address stage that sits directly downstream of the control FSM. It consumes the FSM's fetch and addressing strobes (reset_pc, load_pc, addr_sel, load_ir, load_addr) and the branch-mode select, and drives the RAM address. It holds the fetched instruction and feeds its decoded fields (opcode, op, cond) back to the FSM. It evaluates branch conditions against the datapath status flags N, V, Z.

Parameters:
PC_W, 9, width of PC, data-address register and mem_addr
IR_W, 16, instruction width; equals the RAM word width
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous reset, active-low (0 = reset)
reset_pc  in  1  synchronous PC clear strobe from the FSM
load_pc  in  1  PC update enable
pc_sel  in  2  next-PC source: 00 = PC+1, 01 = conditional branch, 10 = register (datapath_out), 11 = hold
addr_sel  in  1  1 = mem_addr from PC; 0 = mem_addr from data-address register
load_ir  in  1  IR load enable
load_addr  in  1  data-address register load enable
mdata  in  IR_W  RAM read data
datapath_out  in  16  datapath result; low PC_W bits are used
N, V, Z  in  1 each  registered status flags from the datapath
mem_addr  out  PC_W  RAM address
pc  out  PC_W  current PC
ir  out  IR_W  current instruction
opcode  out  3  ir[15:13]
op  out  2  ir[12:11]
cond  out  3  ir[10:8]
sximm5  out  16  sign-extended ir[4:0]
sximm8  out  16  sign-extended ir[7:0]
cond_true  out  1  branch condition currently satisfied
instr_count  out  CNT_W  instructions fetched since reset

Behaviour:
Reset
- reset=0, at any time and asynchronously: pc, data_addr, ir and instr_count all clear to 0.
- All decoded outputs follow from ir=0: opcode=0, op=0, cond=0, sximm5=0, sximm8=0.
- With cond=000, cond_true=1.
- Reset mid-operation discards any pending load.

PC register, on posedge clk with reset=1
- reset_pc=1 (priority over load_pc): pc <= 0.
- Else if load_pc=1, by pc_sel:
  - 00: pc <= pc+1, modulo 2^PC_W (0x1FF wraps to 0x000).
  - 01: if cond_true, pc <= pc + sximm8[PC_W-1:0], modulo 2^PC_W; else pc holds. The PC already points past the branch, so there is no extra +1.
  - 10: pc <= datapath_out[PC_W-1:0].
  - 11: pc holds.
- Else pc holds.

Branch condition (combinational, from cond and the live N/V/Z)
- 000: always true.
- 001: Z.
- 010: !Z.
- 011: N^V.
- 100: (N^V)|Z.
- 101–111: false.

Other registers
- IR: load_ir=1 gives ir <= mdata. load_ir and a PC update in the same cycle act independently; ir captures the mdata present before the edge.
- Data-address register: load_addr=1 gives data_addr <= datapath_out[PC_W-1:0]; otherwise it holds.

mem_addr
- Combinational: addr_sel ? pc : data_addr.
- Zero-cycle latency from addr_sel, pc or data_addr.

Decode fields
- Purely combinational from ir; sximm5 and sximm8 are sign-extended.

instr_count
- Increments by 1 on every clock edge with load_ir=1.
- Saturates at 2^CNT_W−1; no wrap.
- Cleared only by reset=0; reset_pc does not clear it.

Latency
- pc, ir, data_addr and instr_count: one clock after their strobe.
- All other outputs: combinational.

Test Plan:
- Reset: hold reset=0 with random inputs, then release → pc=0, ir=0, instr_count=0, mem_addr=0, cond_true=1; pulse reset_pc with load_pc=1, pc_sel=00 at pc=0x005 → pc=0 after the edge.
- Fetch: addr_sel=1, mdata=0xD105, pulse load_ir, then load_pc with pc_sel=00 → ir=0xD105, opcode=110, op=10, pc=0x001, instr_count=1; repeat from pc=0x1FF → pc=0x000.
- Conditional branch: ir=0x21FE (cond=001, im8=0xFE = −2), pc=0x010, Z=1, load_pc, pc_sel=01 → pc=0x00E; same with Z=0 → pc stays 0x010; cond=100 with N=1, V=0, Z=0 → taken; cond=101 → not taken.
- Register branch and data access: datapath_out=0xFE23, load_pc, pc_sel=10 → pc=0x023; load_addr with datapath_out=0x0140, addr_sel=0 → mem_addr=0x140; addr_sel=1 → mem_addr=pc.
- Priority and saturation: reset_pc=1 and load_pc=1 with pc_sel=10 → pc=0; pc_sel=11 → pc holds; preload instr_count to 0xFFFF via 65535 load_ir cycles, one more load_ir → stays 0xFFFF.
- Async reset mid-operation: assert reset=0 between clock edges while load_ir=1 → ir and instr_count clear immediately, not at the next edge.
